ex_alu_stage: RTL
=================

# ex_alu_stage

Registered execute stage directly downstream of the ALU-control decoder. It consumes the 4-bit ALU control code together with two operands and a destination tag, and produces the result, zero and overflow flags one cycle later. Valid/ready handshakes on both sides let it sit between decode and writeback/branch-resolve logic. It also keeps a wrapping count of completed operations for bring-up visibility.

## Interface
- XLEN, 32: operand/result width (≥ 8)
- TAG_W, 5: destination tag width
- CNT_W, 16: completed-operation counter width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  stage can accept this cycle
- alu_control  in  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB; any other code is illegal
- op_a  in  XLEN  operand A
- op_b  in  XLEN  operand B
- in_tag  in  TAG_W  destination tag, passed through unchanged
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_result  out  XLEN  result
- out_zero  out  1  out_result == 0
- out_ovf  out  1  signed overflow (ADD/SUB only)
- out_illegal  out  1  source code was illegal
- out_tag  out  TAG_W  tag of held result
- op_count  out  CNT_W  number of output transfers since reset

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Compute, all modulo 2^XLEN:
  - AND: a & b
  - OR: a | b
  - ADD: a + b, carry discarded
  - SUB: a − b
  - Illegal code: computed as ADD with out_illegal = 1.
- Flags:
  - ovf for ADD: a[MSB] == b[MSB] && r[MSB] != a[MSB].
  - ovf for SUB: a[MSB] != b[MSB] && r[MSB] != a[MSB].
  - ovf = 0 for AND, OR and illegal codes.
  - zero is computed on the registered result.
- Output register:
  - Loads on every input transfer.
  - out_valid sets on an input transfer and clears on an output transfer that has no simultaneous input transfer.
  - Simultaneous output and input transfer: the new result replaces the old one and out_valid stays 1.
  - Held outputs are stable while out_valid && !out_ready.
- op_count increments by 1 on each output transfer and wraps from 2^CNT_W−1 to 0.
- Order is strictly preserved and nothing is dropped or duplicated.

## Timing
- Reset state: out_valid=0, out_result=0, out_zero=0, out_ovf=0, out_illegal=0, out_tag=0, op_count=0. in_ready=1 in both configurations.
- Latency: an input transfer in cycle N puts the result on the outputs in cycle N+1.
- Throughput: one operation per cycle while out_ready stays high.
- Reset asserted mid-operation: held and buffered results are discarded immediately (asynchronous) and the counter clears.
- in_valid must not be withdrawn before transfer; the block does not check this.

## Configuration
- EX_SKID_EN undefined:
  - in_ready = !out_valid || out_ready, a combinational path from out_ready.
  - Single result register.
- EX_SKID_EN defined:
  - Adds one skid entry and drives in_ready from a register (in_ready = !skid_valid), so there is no combinational path from out_ready.
  - An input transfer while the output is stalled is captured in the skid entry.
  - When the output register frees, the skid entry moves into it on the next edge, ahead of any new input.
  - Maximum occupancy is 2. Latency in the unstalled case is still 1 cycle.
  - Reset clears skid_valid.

## Test plan
- AND/OR: 0x0F0F0F0F with 0x00FF00FF, code 0000 → 0x000F000F; code 0001 → 0x0FFF0FFF. Both with zero=0, ovf=0.
- ADD 0x7FFFFFFF + 1 → 0x80000000 with ovf=1. SUB 5 − 5 → 0 with zero=1, ovf=0. SUB 0x80000000 − 1 → 0x7FFFFFFF with ovf=1.
- Illegal code 1111 on 3 + 4 → result 7, out_illegal=1. Tag 0x1A in → out_tag 0x1A.
- Hold out_ready=0 for 5 cycles with a back-to-back input stream:
  - Outputs remain stable.
  - Without EX_SKID_EN, exactly 1 operation is accepted; with it, exactly 2.
  - After release, results emerge in order, one per cycle.
- Pulse rst_n low mid-stall: out_valid drops within the same cycle, op_count=0 and in_ready=1. The next operation completes with 1-cycle latency.
- Preset op_count to 0xFFFF by running 65535 transfers; one more transfer gives op_count=0x0000.

Source files
------------

// File: rtl/ex_alu_stage.sv
// ex_alu_stage
//
// Registered execute stage that sits right after the ALU-control decoder.
// It takes a 4-bit ALU control code, two operands and a destination tag, and
// presents the result with zero / signed-overflow / illegal-code flags one
// cycle later. Valid/ready handshakes on both sides. A wrapping counter
// records the number of completed output transfers.
//
// Configuration macro: EX_SKID_EN
//   undefined : single result register. in_ready = !out_valid || out_ready,
//               which is a combinational path from out_ready.
//   defined   : adds one skid entry. in_ready comes from a register
//               (!skid_valid), so there is no combinational path from
//               out_ready. Up to two operations can be held.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/ready   input handshake
//   alu_control      0000 AND, 0001 OR, 0010 ADD, 0110 SUB, others illegal
//   op_a, op_b       operands (XLEN)
//   in_tag           destination tag (TAG_W), passed through unchanged
//   out_valid/ready  output handshake
//   out_result       result (XLEN)
//   out_zero         out_result == 0
//   out_ovf          signed overflow, ADD/SUB only
//   out_illegal      source code was illegal (result computed as ADD)
//   out_tag          tag of the held result
//   op_count         output transfers since reset, wraps (CNT_W)

module ex_alu_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] op_count
);

    // Everything the output register holds for one operation.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             illegal;
        logic             ovf;
        logic             zero;
        logic [XLEN-1:0]  result;
    } payload_t;

    payload_t         payload_in;
    payload_t         out_reg;
    logic             out_valid_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN-1:0]  sum;
    logic [XLEN-1:0]  diff;
    logic             in_xfer;
    logic             out_xfer;

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    // ALU function and flags for the operation being presented.
    // The zero flag is captured alongside the result so that it reads 0
    // out of reset even though the reset result is also 0.
    always_comb begin
        payload_in         = '0;
        payload_in.tag     = in_tag;
        payload_in.result  = sum;
        case (alu_control)
            4'b0000: payload_in.result = op_a & op_b;
            4'b0001: payload_in.result = op_a | op_b;
            4'b0010: begin
                payload_in.result = sum;
                payload_in.ovf    = (op_a[XLEN-1] == op_b[XLEN-1]) &&
                                    (sum[XLEN-1] != op_a[XLEN-1]);
            end
            4'b0110: begin
                payload_in.result = diff;
                payload_in.ovf    = (op_a[XLEN-1] != op_b[XLEN-1]) &&
                                    (diff[XLEN-1] != op_a[XLEN-1]);
            end
            default: begin
                // Illegal code: behave as ADD but never flag overflow.
                payload_in.result  = sum;
                payload_in.illegal = 1'b1;
            end
        endcase
        payload_in.zero = (payload_in.result == '0);
    end

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_reg && out_ready;

`ifdef EX_SKID_EN
    payload_t skid_reg;
    logic     skid_valid_reg;
    logic     out_free;

    assign in_ready = !skid_valid_reg;
    // Output register can take new content this edge.
    assign out_free = !out_valid_reg || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg        <= '0;
            out_valid_reg  <= 1'b0;
            skid_reg       <= '0;
            skid_valid_reg <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_reg) begin
                // Skid entry is older than anything arriving now
                // (in_ready is low while it is full), so it goes first.
                out_reg        <= skid_reg;
                out_valid_reg  <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else if (in_xfer) begin
                out_reg       <= payload_in;
                out_valid_reg <= 1'b1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end else if (in_xfer) begin
            // Output stalled: park the new operation in the skid entry.
            skid_reg       <= payload_in;
            skid_valid_reg <= 1'b1;
        end
    end
`else
    assign in_ready = !out_valid_reg || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else if (in_xfer) begin
            // Covers the simultaneous in/out case: new result replaces old.
            out_reg       <= payload_in;
            out_valid_reg <= 1'b1;
        end else if (out_xfer) begin
            out_valid_reg <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (out_xfer) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_result  = out_reg.result;
    assign out_zero    = out_reg.zero;
    assign out_ovf     = out_reg.ovf;
    assign out_illegal = out_reg.illegal;
    assign out_tag     = out_reg.tag;
    assign op_count    = cnt_reg;

endmodule
